// File: rtl/aes_collect_pkg.sv
// Shared types and defaults for the AES output collector.
//   AES_DATA_W  - ciphertext width of the aes_128 core
//   AES_LATENCY - issue-to-output latency of the aes_128 pipeline
//   AES_CNT_W   - width of sequence index / statistics counters
//   res_entry_t - one buffered result: ciphertext plus issue index
package aes_collect_pkg;
  localparam int AES_DATA_W  = 128;
  localparam int AES_LATENCY = 21;
  localparam int AES_CNT_W   = 32;

  typedef struct packed {
    logic [AES_DATA_W-1:0] data;
    logic [AES_CNT_W-1:0]  index;
  } res_entry_t;
endpackage

// File: rtl/collector_fifo.sv
// Show-ahead synchronous FIFO of res_entry_t.
//   clk, rst  - clock, synchronous active-high reset (empties the FIFO)
//   push_i    - write wdata_i (caller guarantees !full_o or pop_i)
//   wdata_i   - entry to write
//   pop_i     - retire head (caller guarantees !empty_o)
//   head_o    - current head, forced to 0 while empty
//   full_o    - all DEPTH entries occupied
//   empty_o   - no entries
module collector_fifo
  import aes_collect_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  res_entry_t wdata_i,
  input  logic       pop_i,
  output res_entry_t head_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  res_entry_t  mem_q [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Gate the head so the outputs read 0 out of reset without clearing storage.
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i)             wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_i && !empty_o)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; when full with a pop, the write lands in the slot
  // being vacated, whose old contents were read combinationally this cycle.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/aes_out_collector.sv
// Collects aes_128 ciphertexts a fixed LATENCY after each issue and presents
// them in issue order on a valid/ready interface tagged with a sequence index.
//   clk, rst      - core clock, synchronous active-high reset
//   issue_i       - a block entered the AES core this cycle
//   aes_out_i     - aes_128 out bus
//   res_valid_o / res_data_o / res_index_o / res_ready_i - result stream
//   in_flight_o   - issued but not yet captured
//   issued_cnt_o  - issues since reset
//   drop_cnt_o    - captures lost to a full FIFO
//   overflow_o    - sticky drop flag
//   checksum_o    - running XOR of popped data when AES_OUT_CHECKSUM_EN is
//                   defined, otherwise constant 0
module aes_out_collector
  import aes_collect_pkg::*;
#(
  parameter int LATENCY    = AES_LATENCY,
  parameter int DATA_W     = AES_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = AES_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_i,
  input  logic [DATA_W-1:0]            aes_out_i,
  output logic                         res_valid_o,
  output logic [DATA_W-1:0]            res_data_o,
  output logic [CNT_W-1:0]             res_index_o,
  input  logic                         res_ready_i,
  output logic [$clog2(LATENCY+1)-1:0] in_flight_o,
  output logic [CNT_W-1:0]             issued_cnt_o,
  output logic [CNT_W-1:0]             drop_cnt_o,
  output logic                         overflow_o,
  output logic [DATA_W-1:0]            checksum_o
);
  localparam int IFW = $clog2(LATENCY+1);

  // Tag/index delay line mirroring the AES pipeline depth.
  logic [LATENCY-1:0]            tag_q, tag_d;
  logic [LATENCY-1:0][CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]              seq_q, seq_d;
  logic [IFW-1:0]                in_flight_q, in_flight_d;
  logic [CNT_W-1:0]              drop_q, drop_d;
  logic                          ovf_q, ovf_d;

  logic       capture, push, pop, full, empty;
  res_entry_t wentry, head;

  always_comb begin
    tag_d    = tag_q;
    idx_d    = idx_q;
    tag_d[0] = issue_i;
    idx_d[0] = seq_q;
    for (int i = 1; i < LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
  end

  assign capture = tag_q[LATENCY-1];

  // The sequence counter doubles as the issued-count statistic.
  assign seq_d = issue_i ? seq_q + CNT_W'(1) : seq_q;

  always_comb begin
    in_flight_d = in_flight_q;
    case ({issue_i, capture})
      2'b10:   in_flight_d = in_flight_q + IFW'(1);
      2'b01:   in_flight_d = in_flight_q - IFW'(1);
      default: in_flight_d = in_flight_q;
    endcase
  end

  assign pop  = res_valid_o && res_ready_i;
  assign push = capture && (!full || pop);

  always_comb begin
    drop_d = drop_q;
    ovf_d  = ovf_q;
    if (capture && full && !pop) begin
      drop_d = drop_q + CNT_W'(1);
      ovf_d  = 1'b1;
    end
  end

  always_comb begin
    wentry       = '0;
    wentry.data  = aes_out_i;
    wentry.index = idx_q[LATENCY-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q       <= '0;
      idx_q       <= '0;
      seq_q       <= '0;
      in_flight_q <= '0;
      drop_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      tag_q       <= tag_d;
      idx_q       <= idx_d;
      seq_q       <= seq_d;
      in_flight_q <= in_flight_d;
      drop_q      <= drop_d;
      ovf_q       <= ovf_d;
    end
  end

  collector_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign res_valid_o  = !empty;
  assign res_data_o   = head.data;
  assign res_index_o  = head.index;
  assign in_flight_o  = in_flight_q;
  assign issued_cnt_o = seq_q;
  assign drop_cnt_o   = drop_q;
  assign overflow_o   = ovf_q;

`ifdef AES_OUT_CHECKSUM_EN
  logic [DATA_W-1:0] cksum_q, cksum_d;

  assign cksum_d = pop ? (cksum_q ^ res_data_o) : cksum_q;

  always_ff @(posedge clk) begin
    if (rst) cksum_q <= '0;
    else     cksum_q <= cksum_d;
  end

  assign checksum_o = cksum_q;
`else
  assign checksum_o = '0;
`endif
endmodule

// File: tb/tb_aes_out_collector.sv
module tb_aes_out_collector;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         issue_i = 1'b0;
  logic [127:0] aes_out_i = '0;
  logic         res_ready_i = 1'b0;
  logic         res_valid_o;
  logic [127:0] res_data_o;
  logic [31:0]  res_index_o;
  logic [4:0]   in_flight_o;
  logic [31:0]  issued_cnt_o;
  logic [31:0]  drop_cnt_o;
  logic         overflow_o;
  logic [127:0] checksum_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_out_collector dut (
    .clk          (clk),
    .rst          (rst),
    .issue_i      (issue_i),
    .aes_out_i    (aes_out_i),
    .res_valid_o  (res_valid_o),
    .res_data_o   (res_data_o),
    .res_index_o  (res_index_o),
    .res_ready_i  (res_ready_i),
    .in_flight_o  (in_flight_o),
    .issued_cnt_o (issued_cnt_o),
    .drop_cnt_o   (drop_cnt_o),
    .overflow_o   (overflow_o),
    .checksum_o   (checksum_o)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    issue_i = 1'b0; res_ready_i = 1'b0; aes_out_i = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_valid"}, res_valid_o, 0);
    chk({pfx, "_data"}, res_data_o, 0);
    chk({pfx, "_index"}, res_index_o, 0);
    chk({pfx, "_inflight"}, in_flight_o, 0);
    chk({pfx, "_issued"}, issued_cnt_o, 0);
    chk({pfx, "_drop"}, drop_cnt_o, 0);
    chk({pfx, "_ovf"}, overflow_o, 0);
    chk({pfx, "_cksum"}, checksum_o, 0);
  endtask

  initial begin
    int nres;
    int bad;
    int found;
    logic [127:0] exp_cksum;

    // Reset state
    tick();
    do_reset();
    chk_zero("rst");

    // Single issue: issue in cycle 0, data in cycle 21, result in cycle 22
    issue_i = 1'b1;
    tick();
    issue_i = 1'b0;
    chk("single_inflight1", in_flight_o, 1);
    chk("single_issued", issued_cnt_o, 1);
    for (int n = 1; n < 20; n++) tick();
    chk("single_noval_c20", res_valid_o, 0);
    tick();
    aes_out_i = 128'h0123456789ABCDEF0123456789ABCDEF;
    chk("single_inflight_c21", in_flight_o, 1);
    chk("single_noval_c21", res_valid_o, 0);
    tick();
    aes_out_i = '0;
    chk("single_valid_c22", res_valid_o, 1);
    chk("single_data", res_data_o, 128'h0123456789ABCDEF0123456789ABCDEF);
    chk("single_index", res_index_o, 0);
    chk("single_inflight0", in_flight_o, 0);
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    chk("single_popped", res_valid_o, 0);

    // Back-to-back: 10 issues, data = cycle number
    do_reset();
    res_ready_i = 1'b1;
    nres = 0;
    for (int n = 0; n < 40; n++) begin
      if (res_valid_o) begin
        chk("b2b_index", res_index_o, nres);
        chk("b2b_data", res_data_o, 21 + nres);
        nres++;
      end
      issue_i = (n < 10);
      aes_out_i = n;
      tick();
    end
    chk("b2b_count", nres, 10);
    chk("b2b_drop", drop_cnt_o, 0);
    chk("b2b_ovf", overflow_o, 0);
    chk("b2b_issued", issued_cnt_o, 10);

    // Overflow: 8 issues with ready low
    do_reset();
    for (int n = 0; n < 30; n++) begin
      if (n == 8) chk("ovf_inflight8", in_flight_o, 8);
      issue_i = (n < 8);
      aes_out_i = 100 + n;
      tick();
    end
    chk("ovf_drop", drop_cnt_o, 4);
    chk("ovf_flag", overflow_o, 1);
    chk("ovf_inflight0", in_flight_o, 0);
    chk("ovf_issued", issued_cnt_o, 8);
    res_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain_valid", res_valid_o, 1);
      chk("ovf_drain_index", res_index_o, i);
      chk("ovf_drain_data", res_data_o, 121 + i);
      tick();
    end
    chk("ovf_drained", res_valid_o, 0);
    chk("ovf_sticky", overflow_o, 1);
    res_ready_i = 1'b0;

    // Full FIFO with pop in the capture cycle: no drop, occupancy stays 4
    do_reset();
    for (int n = 0; n < 25; n++) begin
      issue_i = (n < 5);
      aes_out_i = 200 + n;
      tick();
    end
    chk("fullpop_head_pre", res_index_o, 0);
    res_ready_i = 1'b1;
    aes_out_i = 225;
    tick();
    res_ready_i = 1'b0;
    chk("fullpop_drop", drop_cnt_o, 0);
    chk("fullpop_head", res_index_o, 1);
    res_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("fullpop_valid", res_valid_o, 1);
      chk("fullpop_index", res_index_o, i);
      chk("fullpop_data", res_data_o, 221 + i);
      tick();
    end
    res_ready_i = 1'b0;
    chk("fullpop_empty", res_valid_o, 0);
    chk("fullpop_ovf", overflow_o, 0);

    // Checksum over pops of 1, 2, 4
    do_reset();
    chk("cksum_rst", checksum_o, 0);
    res_ready_i = 1'b1;
    for (int n = 0; n < 30; n++) begin
      issue_i = (n < 3);
      aes_out_i = (n == 21) ? 128'h1 : (n == 22) ? 128'h2 : (n == 23) ? 128'h4 : 128'h0;
      tick();
    end
`ifdef AES_OUT_CHECKSUM_EN
    exp_cksum = 128'h7;
`else
    exp_cksum = 128'h0;
`endif
    chk("cksum_val", checksum_o, exp_cksum);
    res_ready_i = 1'b0;

    // Reset mid-flight
    do_reset();
    res_ready_i = 1'b1;
    for (int n = 0; n < 10; n++) begin
      issue_i = (n < 5);
      aes_out_i = 128'hDEAD0000 + n;
      tick();
    end
    chk("midrst_inflight_pre", in_flight_o, 5);
    issue_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("midrst");
    bad = 0;
    for (int n = 11; n < 30; n++) begin
      if (res_valid_o) bad++;
      aes_out_i = 128'hBEEF0000 + n;
      tick();
    end
    chk("midrst_no_result", bad, 0);
    issue_i = 1'b1;
    tick();
    issue_i = 1'b0;
    res_ready_i = 1'b0;
    found = 0;
    for (int n = 0; n < 40 && found == 0; n++) begin
      aes_out_i = 128'hCAFE;
      if (res_valid_o) found = 1;
      else tick();
    end
    chk("midrst_next_found", found, 1);
    chk("midrst_next_index", res_index_o, 0);
    chk("midrst_next_data", res_data_o, 128'hCAFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
